accel_phase_sequencer: RTL
==========================

// Module: accel_phase_sequencer
// PURPOSE
// - Top-level run controller for the MLP/CNN/RNN datapaths. Accepts ctrl_req_t and walks
//   state_e: LOAD_WEIGHTS -> per tile {LOAD_INPUT -> COMPUTE -> STORE_OUTPUT} -> DONE.
// - Hands each phase to its unit with a start/done pulse handshake and ping-pongs the
//   input/output BRAM banks per tile. Reports ctrl_resp_t to the host register block.
// PARAMETERS
// - TIMEOUT_CYCLES  65535  per-phase watchdog limit (used only with ACCEL_SEQ_WDT_EN)
// - TILE_W          8      width of tile count/index
// PORTS
// - clk            in   1        single clock; all logic rising-edge
// - rst            in   1        synchronous, active-high reset
// - req_i          in   19       ctrl_req_t {start, accel_type, config_data}
// - abort_i        in   1        synchronous abort, level-sampled
// - phase_done_i   in   1        1-cycle pulse from the active phase unit
// - resp_o         out  13       ctrl_resp_t {done, busy, state, error_flags}
// - phase_start_o  out  1        1-cycle pulse on entry to each phase state
// - phase_o        out  3        state_e of the current phase (== resp_o.state)
// - accel_type_o   out  2        accel_type_e latched at accepted start
// - in_bank_o      out  5        BANK_INPUT_0 / BANK_INPUT_1 for the current tile
// - out_bank_o     out  5        BANK_OUTPUT_0 / BANK_OUTPUT_1 for the current tile
// - tile_idx_o     out  TILE_W   current tile, 0-based
// BEHAVIOUR
// - Reset: state IDLE. All outputs 0, except in_bank_o=BANK_INPUT_0 and out_bank_o=BANK_OUTPUT_0.
// - config_data[15]=reuse_weights (skip LOAD_WEIGHTS). config_data[7:0]=tiles N; 0 means 256.
// - Accept: req_i.start=1 in IDLE with accel_type!=2'b11 at cycle T.
//   - At T: latch type/N/reuse; tile_idx=0; clear error_flags.
//   - At T+1: enter LOAD_WEIGHTS, or LOAD_INPUT if reuse_weights=1. busy=1 and phase_start_o=1.
// - accel_type=2'b11 at start: stay IDLE, set error_flags[2]; the start is not accepted.
// - Transitions: phase_done_i=1 in a phase state moves to the next state on the next edge.
//   - Next state asserts phase_start_o in its first cycle.
//   - phase_done_i in the same cycle as phase_start_o is accepted (zero-latency unit allowed).
// - STORE_OUTPUT done: if tile_idx==N-1 go to DONE; else tile_idx+1 and go to LOAD_INPUT.
//   tile_idx wraps only through DONE.
// - Banks: in/out bank = *_0 when tile_idx[0]=0, *_1 when 1; registered with tile_idx.
// - DONE: lasts exactly 1 cycle with resp_o.done=1 and busy=1, then IDLE with busy=0.
//   error_flags hold until the next accepted start.
// - start while busy: ignored; set error_flags[0] (sticky).
// - phase_done_i in IDLE or DONE: ignored; set error_flags[3].
// - abort_i=1 in any non-IDLE state: IDLE next edge, no done pulse, error_flags[4]=1.
//   abort_i outranks phase_done_i in the same cycle. abort_i in IDLE: no effect.
// - error_flags[7:5]: always 0.
// - rst mid-run: everything returns to reset values next edge. No done; flags cleared.
// CONFIGURATION
// - ACCEL_SEQ_WDT_EN defined:
//   - 16-bit counter clears on each phase entry and counts while waiting for phase_done_i.
//   - Count reaching TIMEOUT_CYCLES-1 without done: set error_flags[1], go to DONE,
//     and pulse done (run ends with error).
// - ACCEL_SEQ_WDT_EN undefined: no counter is built; error_flags[1] is tied 0;
//   a phase waits indefinitely.
// STRUCTURE
// - Added to accel_pkg:
//   - CFG_REUSE_W_BIT=15, CFG_TILES_LSB=0, CFG_TILES_MSB=7.
//   - ERR_START_BUSY=0, ERR_WDT=1, ERR_BAD_TYPE=2, ERR_SPURIOUS_DONE=3, ERR_ABORT=4.
// - Existing accel_pkg types are reused: state_e, bram_bank_e, ctrl_req_t, ctrl_resp_t.
// - Sub-module accel_phase_watchdog holds the counter and timeout compare.
//   It is instantiated only under ACCEL_SEQ_WDT_EN.
// TESTING
// - start, type=MLP, cfg=16'h0002, done 3 cycles after each phase_start:
//   -> states LW, LI, CO, SO, LI, CO, SO, DONE.
//   -> in_bank 0,0,0,0,1,1,1. done for 1 cycle, then busy=0, flags=0.
// - cfg=16'h8001 (reuse, 1 tile) -> LOAD_WEIGHTS is never entered.
//   phase_start_o at T+1 in LOAD_INPUT.
// - cfg=16'h0000 -> 256 tiles, tile_idx reaches 255, then DONE.
//   in_bank_o alternates every tile; last tile uses BANK_INPUT_1.
// - start during COMPUTE -> flags[0]=1, run continues.
//   Next start clears flags. type=2'b11 -> stays IDLE, flags[2]=1.
// - abort_i with phase_done_i in COMPUTE -> IDLE next cycle, done never 1, flags[4]=1.
//   rst mid-STORE_OUTPUT -> all outputs at reset values.
// - With ACCEL_SEQ_WDT_EN and TIMEOUT_CYCLES=8, phase_done_i withheld in COMPUTE
//   -> DONE 8 cycles after phase_start, flags[1]=1.
//   Without the macro -> still COMPUTE after 1000 cycles.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared types for the accelerator control path: run states, BRAM bank selects,
// host request/response words, and the sequencer's config/error bit positions.
package accel_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    LOAD_WEIGHTS = 3'd1,
    LOAD_INPUT   = 3'd2,
    COMPUTE      = 3'd3,
    STORE_OUTPUT = 3'd4,
    DONE         = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ACCEL_MLP  = 2'd0,
    ACCEL_CNN  = 2'd1,
    ACCEL_RNN  = 2'd2,
    ACCEL_RSVD = 2'd3
  } accel_type_e;

  typedef enum logic [4:0] {
    BANK_NONE     = 5'b00000,
    BANK_WEIGHTS  = 5'b00001,
    BANK_INPUT_0  = 5'b00010,
    BANK_INPUT_1  = 5'b00100,
    BANK_OUTPUT_0 = 5'b01000,
    BANK_OUTPUT_1 = 5'b10000
  } bram_bank_e;

  typedef struct packed {
    logic        start;
    accel_type_e accel_type;
    logic [15:0] config_data;
  } ctrl_req_t;

  typedef struct packed {
    logic       done;
    logic       busy;
    state_e     state;
    logic [7:0] error_flags;
  } ctrl_resp_t;

  localparam int CFG_REUSE_W_BIT = 15;
  localparam int CFG_TILES_LSB   = 0;
  localparam int CFG_TILES_MSB   = 7;

  localparam int ERR_START_BUSY    = 0;
  localparam int ERR_WDT           = 1;
  localparam int ERR_BAD_TYPE      = 2;
  localparam int ERR_SPURIOUS_DONE = 3;
  localparam int ERR_ABORT         = 4;

  function automatic bram_bank_e in_bank_of(input logic odd);
    return odd ? BANK_INPUT_1 : BANK_INPUT_0;
  endfunction

  function automatic bram_bank_e out_bank_of(input logic odd);
    return odd ? BANK_OUTPUT_1 : BANK_OUTPUT_0;
  endfunction

endpackage

// File: rtl/accel_phase_watchdog.sv
// Per-phase watchdog: a 16-bit counter cleared on every phase entry that flags a
// timeout once it has waited TIMEOUT_CYCLES cycles without the phase finishing.
module accel_phase_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic enter,
  input  logic active,
  output logic timeout
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count_q;

  // Saturates at LIMIT so a stalled phase keeps timeout asserted until it leaves.
  always_ff @(posedge clk) begin
    if (rst || enter || !active) begin
      count_q <= '0;
    end else if (count_q != LIMIT) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign timeout = active && (count_q == LIMIT);

endmodule

// File: rtl/accel_phase_sequencer.sv
// Run controller: walks LOAD_WEIGHTS -> {LOAD_INPUT, COMPUTE, STORE_OUTPUT} per tile -> DONE,
// with start/done pulse handshakes to the phase units. ACCEL_SEQ_WDT_EN adds a per-phase watchdog.
module accel_phase_sequencer
  import accel_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned TILE_W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  ctrl_req_t         req_i,
  input  logic              abort_i,
  input  logic              phase_done_i,
  output ctrl_resp_t        resp_o,
  output logic              phase_start_o,
  output state_e            phase_o,
  output accel_type_e       accel_type_o,
  output bram_bank_e        in_bank_o,
  output bram_bank_e        out_bank_o,
  output logic [TILE_W-1:0] tile_idx_o
);

  // Handshake: phase_start_o pulses for exactly the first cycle of each phase state;
  // the unit answers with a one-cycle phase_done_i pulse, which may coincide with
  // phase_start_o. abort_i outranks phase_done_i in the same cycle.

  state_e            state_q, state_d;
  logic [TILE_W-1:0] tile_q, tile_d;
  logic [TILE_W-1:0] last_q, last_d;
  accel_type_e       type_q, type_d;
  logic [7:0]        flags_q, flags_d;
  logic              phase_start_q;
  logic              phase_enter;
  bram_bank_e        in_bank_q, out_bank_q;
  logic              wdt_timeout;
  logic [7:0]        cfg_tiles;

  assign cfg_tiles = req_i.config_data[CFG_TILES_MSB:CFG_TILES_LSB];

`ifdef ACCEL_SEQ_WDT_EN
  logic in_phase;
  assign in_phase = (state_q == LOAD_WEIGHTS) || (state_q == LOAD_INPUT) ||
                    (state_q == COMPUTE) || (state_q == STORE_OUTPUT);

  accel_phase_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .enter  (phase_enter),
    .active (in_phase),
    .timeout(wdt_timeout)
  );
`else
  assign wdt_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      tile_q        <= '0;
      last_q        <= '0;
      type_q        <= ACCEL_MLP;
      flags_q       <= '0;
      phase_start_q <= 1'b0;
      in_bank_q     <= BANK_INPUT_0;
      out_bank_q    <= BANK_OUTPUT_0;
    end else begin
      state_q       <= state_d;
      tile_q        <= tile_d;
      last_q        <= last_d;
      type_q        <= type_d;
      flags_q       <= flags_d;
      phase_start_q <= phase_enter;
      in_bank_q     <= in_bank_of(tile_d[0]);
      out_bank_q    <= out_bank_of(tile_d[0]);
    end
  end

  always_comb begin
    state_d     = state_q;
    tile_d      = tile_q;
    last_d      = last_q;
    type_d      = type_q;
    flags_d     = flags_q;
    phase_enter = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (phase_done_i) flags_d[ERR_SPURIOUS_DONE] = 1'b1;
        if (req_i.start) begin
          if (req_i.accel_type == ACCEL_RSVD) begin
            flags_d[ERR_BAD_TYPE] = 1'b1;
          end else begin
            // A tile count of 0 wraps to a last index of 255, i.e. 256 tiles.
            type_d      = req_i.accel_type;
            last_d      = TILE_W'(cfg_tiles - 8'd1);
            tile_d      = '0;
            flags_d     = '0;
            phase_enter = 1'b1;
            state_d     = req_i.config_data[CFG_REUSE_W_BIT] ? LOAD_INPUT : LOAD_WEIGHTS;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        tile_d  = '0;
        if (phase_done_i) flags_d[ERR_SPURIOUS_DONE] = 1'b1;
        if (req_i.start)  flags_d[ERR_START_BUSY]    = 1'b1;
        if (abort_i)      flags_d[ERR_ABORT]         = 1'b1;
      end
      default: begin
        if (req_i.start) flags_d[ERR_START_BUSY] = 1'b1;
        if (abort_i) begin
          state_d            = IDLE;
          flags_d[ERR_ABORT] = 1'b1;
        end else if (phase_done_i) begin
          phase_enter = 1'b1;
          case (state_q)
            LOAD_WEIGHTS: state_d = LOAD_INPUT;
            LOAD_INPUT:   state_d = COMPUTE;
            COMPUTE:      state_d = STORE_OUTPUT;
            STORE_OUTPUT: begin
              if (tile_q == last_q) begin
                state_d     = DONE;
                phase_enter = 1'b0;
              end else begin
                tile_d  = tile_q + 1'b1;
                state_d = LOAD_INPUT;
              end
            end
            default: begin
              state_d     = IDLE;
              phase_enter = 1'b0;
            end
          endcase
        end else if (wdt_timeout) begin
          flags_d[ERR_WDT] = 1'b1;
          state_d          = DONE;
        end
      end
    endcase
  end

  assign resp_o.done        = (state_q == DONE);
  assign resp_o.busy        = (state_q != IDLE);
  assign resp_o.state       = state_q;
  assign resp_o.error_flags = flags_q;

  assign phase_start_o = phase_start_q;
  assign phase_o       = state_q;
  assign accel_type_o  = type_q;
  assign in_bank_o     = in_bank_q;
  assign out_bank_o    = out_bank_q;
  assign tile_idx_o    = tile_q;

endmodule
